gemm_output_requant: RTL and testbench
======================================

// Module: gemm_output_requant
// PURPOSE
//  Downstream stage of the tiled 3D GEMM controller. After the controller's sticky done, reads the
//  held C_full accumulator matrix in row-major order and applies per-column bias, unsigned scale,
//  rounding right-shift, optional ReLU and int8 saturation. Emits one element per handshake on a
//  valid/ready stream toward the activation writeback path.
// PARAMETERS
//  M_TOTAL  32  rows of C_full
//  N_TOTAL  48  columns of C_full
//  ACC_W_P  ACC_W (backbone_pkg)  accumulator width of C_full and bias
//  OUT_W    8   signed output width
//  SCALE_W  16  unsigned requant multiplier width
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   synchronous reset, active-high
//  start      in   1                   begin pass; sampled only in IDLE
//  busy       out  1                   high from the cycle after start acceptance until the last handshake
//  done       out  1                   sticky; set on last handshake, cleared by next accepted start
//  C_full     in   ACC_W_P [M][N]      signed accumulators; held stable while busy
//  bias       in   ACC_W_P [N]         signed per-column bias
//  cfg_scale  in   SCALE_W             unsigned multiplier
//  cfg_shift  in   5                   right-shift amount, 0..31
//  cfg_relu   in   1                   1 = clamp negatives to 0
//  out_valid  out  1                   output element valid
//  out_ready  in   1                   consumer accepts when valid&&ready
//  out_data   out  OUT_W               signed requantized value
//  out_row    out  $clog2(M_TOTAL)     row index of out_data
//  out_col    out  $clog2(N_TOTAL)     column index of out_data
//  out_last   out  1                   high with element (M_TOTAL-1, N_TOTAL-1)
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, out_valid, out_last = 0; out_data, out_row, out_col = 0;
//    all pipeline valid bits = 0. Reset mid-pass aborts immediately. No partial output survives.
//  - FSM states:
//    IDLE -> RUN on start.
//    RUN issues indices (r,c) row-major, c fastest. After issuing (M-1,N-1), goes to DRAIN.
//    DRAIN -> DONE when the last element handshakes.
//    DONE -> IDLE next cycle.
//  - Config capture: cfg_scale, cfg_shift and cfg_relu are captured at start acceptance and held
//    for the whole pass. start while not in IDLE is ignored.
//  - Pipeline: 3 stages, all sharing one enable, adv = !out_valid || out_ready.
//    S1: sum = C_full[r][c] + bias[c], width ACC_W_P+1, sign-extended, no overflow.
//    S2: prod = sum * {1'b0,cfg_scale}, signed, width ACC_W_P+SCALE_W+2.
//    S3: if shift>0, rnd = (prod + (1<<(shift-1))) >>> shift (round half toward +inf); else rnd = prod.
//        If relu and rnd<0, rnd = 0. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//        Register into out_data, out_row, out_col, out_last.
//  - Latency: with out_ready=1, the first out_valid is visible after the 3rd rising edge following
//    the start-sampling edge. Throughput is 1 element per cycle.
//  - Backpressure: while out_valid && !out_ready, all stages and the index counter freeze.
//    out_data, out_row, out_col and out_last stay stable. No element is dropped or duplicated.
//  - done is set in the cycle after the last handshake, together with busy falling.
//    start accepted while done=1 clears done on the same edge that enters RUN.
//  - Index counter: wraps c to 0 at N_TOTAL-1 and increments r. No wrap past (M-1,N-1).
// TESTING
//  T1 M=2,N=3,scale=1,shift=0,bias=0,relu=0, C row0={100,200,-300}
//     -> out row0 = {100,127,-128}; out_last only at (1,2).
//  T2 scale=1, shift=1, C={5,-5,3}, bias=0 -> {3,-2,2}; scale=3,shift=2,C=7 -> 5 (21+2=23>>>2).
//  T3 C=-10, bias[0]=4: relu=1 -> 0; relu=0 -> -6; bias[0]=200,C=0 -> 127.
//  T4 out_ready pattern 1,0,0,1,0,1 across a pass -> exact row-major order;
//     data held during stalls; total handshakes = M*N.
//  T5 assert rst after 2 handshakes -> next cycle out_valid=0, busy=0, done=0;
//     a new start restarts at (0,0).
//  T6 start pulsed while busy -> ignored, single pass; done stays 1 across idle cycles
//     until the next start, which clears it.

Source files
------------

// File: rtl/gemm_output_requant_if.sv
// Output element stream of the GEMM requantizer: one int8 value per valid/ready handshake,
// tagged with its row/column position and an end-of-matrix marker.
interface gemm_output_requant_if #(
  parameter int OUT_W = 8,
  parameter int ROW_W = 5,
  parameter int COL_W = 6
);
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;
  logic                    out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/gemm_output_requant.sv
// Walks the held C_full matrix row-major and streams bias + scale + rounding shift + ReLU +
// int8 saturation results through a 3-stage pipeline that stalls as a whole on backpressure.
module gemm_output_requant #(
  parameter int M_TOTAL = 32,
  parameter int N_TOTAL = 48,
  parameter int ACC_W_P = 32,
  parameter int OUT_W   = 8,
  parameter int SCALE_W = 16,
  localparam int ROW_W  = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1,
  localparam int COL_W  = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic signed [ACC_W_P-1:0] C_full [M_TOTAL][N_TOTAL],
  input  logic signed [ACC_W_P-1:0] bias [N_TOTAL],
  input  logic [SCALE_W-1:0]        cfg_scale,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  gemm_output_requant_if.master     out_if
);
  localparam int SUM_W  = ACC_W_P + 1;
  localparam int PROD_W = ACC_W_P + SCALE_W + 2;
  localparam int RND_W  = PROD_W + 1;
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [SCALE_W-1:0]      scale_q, scale_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic                    done_q, done_d;

  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic [ROW_W-1:0]        s1_row_q, s1_row_d;
  logic [COL_W-1:0]        s1_col_q, s1_col_d;

  logic                     s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic signed [PROD_W-1:0] s2_prod_q, s2_prod_d;
  logic [ROW_W-1:0]         s2_row_q, s2_row_d;
  logic [COL_W-1:0]         s2_col_q, s2_col_d;

  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [ROW_W-1:0]        out_row_q, out_row_d;
  logic [COL_W-1:0]        out_col_q, out_col_d;

  logic adv, start_acc, issue, col_end, row_end, issue_last, last_hs;
  logic signed [RND_W-1:0] rnd_add, rnd;
  logic signed [OUT_W-1:0] sat_val;

  assign adv        = !out_valid_q || out_if.out_ready;
  assign start_acc  = (state_q == IDLE) && start;
  assign col_end    = (col_q == COL_W'(N_TOTAL - 1));
  assign row_end    = (row_q == ROW_W'(M_TOTAL - 1));
  assign issue_last = issue && col_end && row_end;
  assign last_hs    = out_valid_q && out_if.out_ready && out_last_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = RUN;
      RUN:     if (issue_last) state_d = DRAIN;
      DRAIN:   if (last_hs)    state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN) || (state_q == DRAIN);
    issue = (state_q == RUN) && adv;
  end

  // Rounding add is sized one bit above the product so the half-LSB bias can never wrap.
  always_comb begin
    rnd_add = '0;
    if (shift_q != 5'd0) rnd_add = RND_W'(1) << (shift_q - 5'd1);
    rnd = (RND_W'(s2_prod_q) + rnd_add) >>> shift_q;
    if (relu_q && rnd[RND_W-1]) rnd = '0;
    if (rnd > SAT_MAX)      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    else if (rnd < SAT_MIN) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    else                    sat_val = rnd[OUT_W-1:0];
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    scale_d = scale_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    done_d  = done_q;
    if (start_acc) begin
      row_d   = '0;
      col_d   = '0;
      scale_d = cfg_scale;
      shift_d = cfg_shift;
      relu_d  = cfg_relu;
      done_d  = 1'b0;
    end else if (issue) begin
      if (!col_end) begin
        col_d = col_q + COL_W'(1);
      end else if (!row_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end
    end
    if (last_hs) done_d = 1'b1;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_sum_d    = s1_sum_q;
    s1_row_d    = s1_row_q;
    s1_col_d    = s1_col_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_prod_d   = s2_prod_q;
    s2_row_d    = s2_row_q;
    s2_col_d    = s2_col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (adv) begin
      s1_valid_d  = issue;
      s1_last_d   = issue_last;
      s1_sum_d    = SUM_W'(C_full[row_q][col_q]) + SUM_W'(bias[col_q]);
      s1_row_d    = row_q;
      s1_col_d    = col_q;
      s2_valid_d  = s1_valid_q;
      s2_last_d   = s1_last_q;
      s2_prod_d   = PROD_W'(s1_sum_q) * PROD_W'($signed({1'b0, scale_q}));
      s2_row_d    = s1_row_q;
      s2_col_d    = s1_col_q;
      out_valid_d = s2_valid_q;
      out_last_d  = s2_last_q;
      out_data_d  = sat_val;
      out_row_d   = s2_row_q;
      out_col_d   = s2_col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0; col_q <= '0; scale_q <= '0; shift_q <= '0; relu_q <= 1'b0; done_q <= 1'b0;
      s1_valid_q <= 1'b0; s1_last_q <= 1'b0; s1_sum_q <= '0; s1_row_q <= '0; s1_col_q <= '0;
      s2_valid_q <= 1'b0; s2_last_q <= 1'b0; s2_prod_q <= '0; s2_row_q <= '0; s2_col_q <= '0;
      out_valid_q <= 1'b0; out_last_q <= 1'b0; out_data_q <= '0; out_row_q <= '0; out_col_q <= '0;
    end else begin
      row_q <= row_d; col_q <= col_d; scale_q <= scale_d; shift_q <= shift_d;
      relu_q <= relu_d; done_q <= done_d;
      s1_valid_q <= s1_valid_d; s1_last_q <= s1_last_d; s1_sum_q <= s1_sum_d;
      s1_row_q <= s1_row_d; s1_col_q <= s1_col_d;
      s2_valid_q <= s2_valid_d; s2_last_q <= s2_last_d; s2_prod_q <= s2_prod_d;
      s2_row_q <= s2_row_d; s2_col_q <= s2_col_d;
      out_valid_q <= out_valid_d; out_last_q <= out_last_d; out_data_q <= out_data_d;
      out_row_q <= out_row_d; out_col_q <= out_col_d;
    end
  end

  assign done             = done_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_row   = out_row_q;
  assign out_if.out_col   = out_col_q;
  assign out_if.out_last  = out_last_q;
endmodule

// File: tb/tb_gemm_output_requant.sv
// Directed bench for gemm_output_requant on a 2x3 matrix: arithmetic corners, latency,
// backpressure ordering, mid-pass reset and start/done handshaking.
module tb_gemm_output_requant;
  localparam int M = 2;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst, start, busy, done, cfg_relu;
  logic signed [31:0] c_full [M][N];
  logic signed [31:0] bias [N];
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic signed [7:0] exp_v [6];

  int vectors = 0;
  int miscompares = 0;

  gemm_output_requant_if #(.OUT_W(8), .ROW_W(1), .COL_W(2)) out_if ();

  gemm_output_requant #(
    .M_TOTAL(M), .N_TOTAL(N), .ACC_W_P(32), .OUT_W(8), .SCALE_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .C_full(c_full), .bias(bias), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .out_if(out_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge with out_ready=1; returns at the negedge after the handshake edge.
  task automatic expect_elem(input string tag, input int r, input int c,
                             input logic signed [7:0] d, input logic l);
    int n = 0;
    while (out_if.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, out_if.out_valid, 1);
    chk({tag, "_data"}, out_if.out_data, d);
    chk({tag, "_row"}, out_if.out_row, r);
    chk({tag, "_col"}, out_if.out_col, c);
    chk({tag, "_last"}, out_if.out_last, l);
    $display("elem %s (%0d,%0d) data=%0d last=%0b", tag, out_if.out_row, out_if.out_col,
             out_if.out_data, out_if.out_last);
    @(negedge clk);
  endtask

  task automatic check_pass(input string tag, input logic signed [7:0] e [6]);
    for (int i = 0; i < 6; i++)
      expect_elem($sformatf("%s_%0d", tag, i), i / N, i % N, e[i], i == 5);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_end"}, done, 1);
  endtask

  initial begin
    int idx;
    int cyc;
    logic pat [6];
    rst = 1'b1; start = 1'b0; out_if.out_ready = 1'b1;
    cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
    c_full = '{'{100, 200, -300}, '{1, 2, 3}};
    bias = '{0, 0, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_if.out_valid, 0);
    chk("rst_data", out_if.out_data, 0);
    chk("rst_last", out_if.out_last, 0);

    // T1 with latency check: valid appears after the 3rd edge following the start edge
    exp_v = '{100, 127, -128, 1, 2, 3};
    pulse_start();
    chk("t1_busy", busy, 1);
    @(negedge clk); chk("t1_lat1", out_if.out_valid, 0);
    @(negedge clk); chk("t1_lat2", out_if.out_valid, 0);
    @(negedge clk); chk("t1_lat3", out_if.out_valid, 1);
    check_pass("t1", exp_v);

    // T2 rounding shift
    cfg_shift = 5'd1;
    c_full = '{'{5, -5, 3}, '{7, 0, -7}};
    exp_v = '{3, -2, 2, 4, 0, -3};
    pulse_start();
    check_pass("t2a", exp_v);
    cfg_scale = 16'd3; cfg_shift = 5'd2;
    c_full = '{'{7, -5, 3}, '{7, 0, -7}};
    exp_v = '{5, -4, 2, 5, 0, -5};
    pulse_start();
    check_pass("t2b", exp_v);

    // T3 bias, ReLU, positive saturation
    cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_relu = 1'b1;
    c_full = '{'{-10, -3, 50}, '{0, -1, 1}};
    bias = '{4, 0, 0};
    exp_v = '{0, 0, 50, 4, 0, 1};
    pulse_start();
    check_pass("t3_relu", exp_v);
    cfg_relu = 1'b0;
    exp_v = '{-6, -3, 50, 4, -1, 1};
    pulse_start();
    check_pass("t3_norelu", exp_v);
    c_full[0][0] = 0;
    bias = '{200, 0, 0};
    exp_v = '{127, -3, 50, 127, -1, 1};
    pulse_start();
    check_pass("t3_sat", exp_v);

    // T4 backpressure with ready pattern 1,0,0,1,0,1
    c_full = '{'{100, 200, -300}, '{1, 2, 3}};
    bias = '{0, 0, 0};
    exp_v = '{100, 127, -128, 1, 2, 3};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pulse_start();
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 200) begin
      out_if.out_ready = pat[cyc % 6];
      if (out_if.out_valid === 1'b1) begin
        chk($sformatf("t4_data_%0d", idx), out_if.out_data, exp_v[idx]);
        chk($sformatf("t4_row_%0d", idx), out_if.out_row, idx / N);
        chk($sformatf("t4_col_%0d", idx), out_if.out_col, idx % N);
        $display("t4 cyc=%0d ready=%0b (%0d,%0d) data=%0d", cyc, out_if.out_ready,
                 out_if.out_row, out_if.out_col, out_if.out_data);
        if (out_if.out_ready) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    out_if.out_ready = 1'b1;
    chk("t4_handshakes", idx, 6);
    chk("t4_no_dup", out_if.out_valid, 0);
    chk("t4_done", done, 1);

    // T5 reset after two handshakes
    pulse_start();
    expect_elem("t5_pre0", 0, 0, 100, 1'b0);
    expect_elem("t5_pre1", 0, 1, 127, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_valid", out_if.out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_col", out_if.out_col, 0);
    pulse_start();
    check_pass("t5_restart", exp_v);

    // T6 start while busy is ignored; done sticky until next start; config held mid-pass
    pulse_start();
    start = 1'b1;
    cfg_shift = 5'd3;
    @(negedge clk);
    start = 1'b0;
    check_pass("t6", exp_v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_idle_valid_%0d", i), out_if.out_valid, 0);
      chk($sformatf("t6_idle_done_%0d", i), done, 1);
    end
    cfg_shift = 5'd0;
    pulse_start();
    chk("t6_done_clr", done, 0);
    chk("t6_busy_set", busy, 1);
    check_pass("t6_next", exp_v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
